// File: rtl/group_match_pkg.sv
// Shared types and per-group classification functions for the group match pipeline.
package group_match_pkg;

    localparam int unsigned GROUP_W = 5;

    typedef enum logic [1:0] {
        MODE_ANY    = 2'd0,
        MODE_ALL    = 2'd1,
        MODE_THRESH = 2'd2,
        MODE_QUIET  = 2'd3
    } mode_e;

    // ACTIVE flag of one 5-bit group, g[0] is the group LSB.
    function automatic logic grp_h(input logic [GROUP_W-1:0] g);
        return (~g[0] & ((g[1] & ~g[3] & g[4]) | (~g[1] & g[3] & ~g[4])))
             | (g[1] & (g[2] | (g[0] & g[3] & ~g[4])))
             | (g[0] & (g[2] | (~g[1] & ~g[3] & g[4])));
    endfunction

    // QUIET flag of one 5-bit group.
    function automatic logic grp_q(input logic [GROUP_W-1:0] g);
        return ~g[2] & (((g[3] | ~g[4]) & (g[0] ^ g[1])) | ((~g[3] | g[4]) & g[0] & g[1]));
    endfunction

endpackage

// File: rtl/group_match_pipe_if.sv
// Input and result handshakes of group_match_pipe; master drives transactions, slave is the block.
interface group_match_pipe_if #(
    parameter int unsigned NUM_GROUPS = 5
);
    import group_match_pkg::*;

    localparam int unsigned CW = $clog2(NUM_GROUPS + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic [GROUP_W*NUM_GROUPS-1:0] in_data;
    logic [1:0]                    in_mode;
    logic [CW-1:0]                 in_thresh;
    logic                          out_valid;
    logic                          out_ready;
    logic                          out_match;
    logic [CW-1:0]                 out_hcount;

    modport master (
        output in_valid, in_data, in_mode, in_thresh, out_ready,
        input  in_ready, out_valid, out_match, out_hcount
    );

    modport slave (
        input  in_valid, in_data, in_mode, in_thresh, out_ready,
        output in_ready, out_valid, out_match, out_hcount
    );

endinterface

// File: rtl/group_classify.sv
// Combinational classification of one 5-bit group into its ACTIVE and QUIET flags.
module group_classify
    import group_match_pkg::*;
(
    input  logic [GROUP_W-1:0] grp_i,
    output logic               h_o,
    output logic               q_o
);

    always_comb begin
        h_o = grp_h(grp_i);
        q_o = grp_q(grp_i);
    end

endmodule

// File: rtl/group_match_pipe.sv
// Two-stage valid/ready pipeline: classify groups, reduce under the per-transaction mode,
// and keep a saturating count of matching results.
module group_match_pipe
    import group_match_pkg::*;
#(
    parameter int unsigned NUM_GROUPS = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] hit_count,
    group_match_pipe_if.slave bus
);

    localparam int unsigned CW = $clog2(NUM_GROUPS + 1);

    logic [NUM_GROUPS-1:0] h_vec;
    logic [NUM_GROUPS-1:0] q_vec;

    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_cls
        group_classify u_cls (
            .grp_i (bus.in_data[GROUP_W*k +: GROUP_W]),
            .h_o   (h_vec[k]),
            .q_o   (q_vec[k])
        );
    end

    logic                  s1_v_q, s1_v_d;
    logic [NUM_GROUPS-1:0] s1_h_q, s1_h_d;
    logic [NUM_GROUPS-1:0] s1_q_q, s1_q_d;
    mode_e                 s1_mode_q, s1_mode_d;
    logic [CW-1:0]         s1_thresh_q, s1_thresh_d;
    logic                  s2_v_q, s2_v_d;
    logic                  match_q, match_d;
    logic [CW-1:0]         hcount_q, hcount_d;
    logic [CNT_W-1:0]      hit_count_q, hit_count_d;

    logic          s1_load, s2_load, in_fire, out_fire, s1_advance;
    logic [CW-1:0] s1_hcount;
    logic          s1_match;

    // S2 frees up when empty or draining; S1 frees up when empty or moving into S2.
    assign s2_load    = ~s2_v_q | bus.out_ready;
    assign s1_load    = ~s1_v_q | s2_load;
    assign in_fire    = bus.in_valid & s1_load;
    assign out_fire   = s2_v_q & bus.out_ready;
    assign s1_advance = s1_v_q & s2_load;

    assign bus.in_ready   = s1_load;
    assign bus.out_valid  = s2_v_q;
    assign bus.out_match  = match_q;
    assign bus.out_hcount = hcount_q;
    assign hit_count      = hit_count_q;

    always_comb begin
        s1_hcount = '0;
        for (int unsigned i = 0; i < NUM_GROUPS; i++) begin
            s1_hcount = s1_hcount + CW'(s1_h_q[i]);
        end
    end

    // Threshold above NUM_GROUPS can never be reached by the popcount, so it never matches.
    always_comb begin
        s1_match = 1'b0;
        unique case (s1_mode_q)
            MODE_ANY:    s1_match = |s1_h_q;
            MODE_ALL:    s1_match = &s1_h_q;
            MODE_THRESH: s1_match = (s1_hcount >= s1_thresh_q);
            MODE_QUIET:  s1_match = ~(|s1_h_q) & (|s1_q_q);
            default:     s1_match = 1'b0;
        endcase
    end

    always_comb begin
        s1_v_d      = s1_load ? in_fire : s1_v_q;
        s1_h_d      = s1_h_q;
        s1_q_d      = s1_q_q;
        s1_mode_d   = s1_mode_q;
        s1_thresh_d = s1_thresh_q;
        if (in_fire) begin
            s1_h_d      = h_vec;
            s1_q_d      = q_vec;
            s1_mode_d   = mode_e'(bus.in_mode);
            s1_thresh_d = bus.in_thresh;
        end

        s2_v_d   = s2_load ? s1_v_q : s2_v_q;
        match_d  = match_q;
        hcount_d = hcount_q;
        if (s1_advance) begin
            match_d  = s1_match;
            hcount_d = s1_hcount;
        end
    end

    always_comb begin
        hit_count_d = hit_count_q;
        if (clr_cnt) begin
            hit_count_d = '0;
        end else if (out_fire && match_q && !(&hit_count_q)) begin
            hit_count_d = hit_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q      <= 1'b0;
            s1_h_q      <= '0;
            s1_q_q      <= '0;
            s1_mode_q   <= MODE_ANY;
            s1_thresh_q <= '0;
            s2_v_q      <= 1'b0;
            match_q     <= 1'b0;
            hcount_q    <= '0;
            hit_count_q <= '0;
        end else begin
            s1_v_q      <= s1_v_d;
            s1_h_q      <= s1_h_d;
            s1_q_q      <= s1_q_d;
            s1_mode_q   <= s1_mode_d;
            s1_thresh_q <= s1_thresh_d;
            s2_v_q      <= s2_v_d;
            match_q     <= match_d;
            hcount_q    <= hcount_d;
            hit_count_q <= hit_count_d;
        end
    end

endmodule
